// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exponent-unit mode codes, FSM states and bias helper.
package fpu_pkg;

  typedef enum logic [1:0] {
    EXP_DIFF = 2'b00,
    EXP_MUL  = 2'b01,
    EXP_DIV  = 2'b10,
    EXP_NORM = 2'b11
  } exp_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_S1   = 2'b01,
    ST_S2   = 2'b10
  } exp_state_e;

  // IEEE-style exponent bias for an ew-bit exponent field.
  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage

// File: rtl/exp_range_check.sv
// Classifies a step-2 exponent value against the representable range and
// optionally saturates it to the EW-bit field.
module exp_range_check
  import fpu_pkg::*;
#(
  parameter int EW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic signed [EW+1:0] r,
  input  exp_mode_e            mode,
  output logic        [EW-1:0] result,
  output logic                 overflow,
  output logic                 underflow
);

  // Largest finite biased exponent; all-ones is reserved for Inf/NaN.
  localparam logic signed [EW+1:0] MAX_FIN = (EW+2)'((2 ** EW) - 2);

  // Flag and clamp the candidate result according to the operation mode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    overflow  = 1'b0;
    underflow = 1'b0;
    result    = r[EW-1:0];
    if (mode == EXP_MUL || mode == EXP_DIV) begin
      overflow = (r > MAX_FIN);
    end
    if (mode != EXP_DIFF) begin
      underflow = (r <= 0);
    end
    if (SAT) begin
      if (overflow) begin
        result = '1;
      end else if (underflow) begin
        result = '0;
      end
    end
  end

endmodule

// File: rtl/exp_operation_unit.sv
// Two-step exponent arithmetic engine (DIFF/MUL/DIV/NORM) built around one
// shared signed adder, with range classification and registered flags.
module exp_operation_unit
  import fpu_pkg::*;
#(
  parameter int EW   = 8,
  parameter int BIAS = bias_of(EW),
  parameter bit SAT  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          clr_i,
  input  logic [1:0]    mode_i,
  input  logic [EW-1:0] oper_a_i,
  input  logic [EW-1:0] oper_b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [EW-1:0] data_result_o,
  output logic          overflow_flag_o,
  output logic          underflow_flag_o,
  output logic          swap_flag_o
);

  // Two guard bits hold -(2^EW-1) .. 2*(2^EW-1) without wrapping.
  localparam int AW = EW + 2;
  localparam logic signed [AW-1:0] BIAS_V = AW'(BIAS);

  exp_state_e            state, state_nxt;
  exp_mode_e             mode_q;
  logic [EW-1:0]         a_q, b_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  add_x, add_y, sum;
  logic                  add_neg;
  logic [EW-1:0]         rc_result;
  logic                  rc_ovf, rc_unf;
  logic                  accept;

  assign accept = (state == ST_IDLE) && start_i && !clr_i;
  assign busy_o = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state <= state_nxt;
    end
  end

  // Next-state logic; clr_i overrides start_i and aborts any step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = ST_S1;
      ST_S1:   state_nxt = clr_i ? ST_IDLE : ST_S2;
      ST_S2:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/negation mux feeding the single shared adder for both steps.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_neg = 1'b0;
    if (state == ST_S1) begin
      add_x   = $signed({2'b00, a_q});
      add_y   = $signed({2'b00, b_q});
      add_neg = (mode_q != EXP_MUL);
    end else if (state == ST_S2) begin
      unique case (mode_q)
        EXP_DIFF: begin
          // |acc| computed as 0 - acc when the difference went negative.
          if (acc_q[AW-1]) begin
            add_y   = acc_q;
            add_neg = 1'b1;
          end else begin
            add_x = acc_q;
          end
        end
        EXP_MUL: begin
          add_x   = acc_q;
          add_y   = BIAS_V;
          add_neg = 1'b1;
        end
        EXP_DIV: begin
          add_x = acc_q;
          add_y = BIAS_V;
        end
        default: add_x = acc_q;
      endcase
    end
  end

  assign sum = add_x + (add_neg ? -add_y : add_y);

  exp_range_check #(
    .EW  (EW),
    .SAT (SAT)
  ) u_range_check (
    .r         (sum),
    .mode      (mode_q),
    .result    (rc_result),
    .overflow  (rc_ovf),
    .underflow (rc_unf)
  );

  // Datapath: capture operands, accumulate step 1, register step-2 result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these are plain flops, not memory, so all of them reset.
      mode_q           <= EXP_DIFF;
      a_q              <= '0;
      b_q              <= '0;
      acc_q            <= '0;
      done_o           <= 1'b0;
      data_result_o    <= '0;
      overflow_flag_o  <= 1'b0;
      underflow_flag_o <= 1'b0;
      swap_flag_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        mode_q <= exp_mode_e'(mode_i);
        a_q    <= oper_a_i;
        b_q    <= oper_b_i;
      end
      if (state == ST_S1 && !clr_i) begin
        acc_q <= sum;
      end
      if (state == ST_S2 && !clr_i) begin
        data_result_o    <= rc_result;
        overflow_flag_o  <= rc_ovf;
        underflow_flag_o <= rc_unf;
        swap_flag_o      <= (mode_q == EXP_DIFF) && acc_q[AW-1];
        done_o           <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exp_operation_unit.sv
// Scoreboard bench for exp_operation_unit: a saturating and a raw (SAT=0)
// instance share stimulus; monitors pop expectations on each done_o.
module tb_exp_operation_unit;
  import fpu_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       unf;
    logic       swap;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] oper_a = '0;
  logic [7:0] oper_b = '0;

  logic       busy_sat, done_sat, ovf_sat, unf_sat, swap_sat;
  logic [7:0] res_sat;
  logic       busy_raw, done_raw, ovf_raw, unf_raw, swap_raw;
  logic [7:0] res_raw;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t q_sat[$];
  exp_t q_raw[$];

  exp_operation_unit #(.EW(8), .BIAS(127), .SAT(1'b1)) dut_sat (
    .clk (clk), .rst (rst), .start_i (start), .clr_i (clr), .mode_i (mode),
    .oper_a_i (oper_a), .oper_b_i (oper_b), .busy_o (busy_sat),
    .done_o (done_sat), .data_result_o (res_sat), .overflow_flag_o (ovf_sat),
    .underflow_flag_o (unf_sat), .swap_flag_o (swap_sat)
  );

  exp_operation_unit #(.EW(8), .BIAS(127), .SAT(1'b0)) dut_raw (
    .clk (clk), .rst (rst), .start_i (start), .clr_i (clr), .mode_i (mode),
    .oper_a_i (oper_a), .oper_b_i (oper_b), .busy_o (busy_raw),
    .done_o (done_raw), .data_result_o (res_raw), .overflow_flag_o (ovf_raw),
    .underflow_flag_o (unf_raw), .swap_flag_o (swap_raw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Expected values for both instances of one operation.
  task automatic push(input int due, input logic [7:0] r_sat,
                      input logic [7:0] r_raw, input logic o, input logic u,
                      input logic s);
    exp_t e;
    e.due = due; e.ovf = o; e.unf = u; e.swap = s;
    e.res = r_sat;
    q_sat.push_back(e);
    e.res = r_raw;
    q_raw.push_back(e);
  endtask

  // Issue one op at the next negedge; returns in S2 so the following call
  // drives start during the done cycle (back-to-back).
  task automatic issue(input exp_mode_e m, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r_sat,
                       input logic [7:0] r_raw, input logic o, input logic u,
                       input logic s);
    @(negedge clk);
    start = 1'b1; mode = m; oper_a = a; oper_b = b;
    @(posedge clk); #1;
    check("busy_s1", busy_sat, 1);
    push(cyc + 2, r_sat, r_raw, o, u, s);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_s2", busy_sat, 1);
  endtask

  // Monitor for the saturating instance.
  initial begin : mon_sat
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (done_sat) begin
        check("sat_expected_done", q_sat.size() != 0, 1);
        if (q_sat.size() != 0) begin
          e = q_sat.pop_front();
          check("sat_latency", cyc, e.due);
          check("sat_result", res_sat, e.res);
          check("sat_ovf", ovf_sat, e.ovf);
          check("sat_unf", unf_sat, e.unf);
          check("sat_swap", swap_sat, e.swap);
          check("sat_busy_at_done", busy_sat, 0);
        end
      end
    end
  end

  // Monitor for the raw (non-saturating) instance.
  initial begin : mon_raw
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (done_raw) begin
        check("raw_expected_done", q_raw.size() != 0, 1);
        if (q_raw.size() != 0) begin
          e = q_raw.pop_front();
          check("raw_latency", cyc, e.due);
          check("raw_result", res_raw, e.res);
          check("raw_ovf", ovf_raw, e.ovf);
          check("raw_unf", unf_raw, e.unf);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy_sat, 0);
    check({tag, "_done"}, done_sat, 0);
    check({tag, "_result"}, res_sat, 0);
    check({tag, "_ovf"}, ovf_sat, 0);
    check({tag, "_unf"}, unf_sat, 0);
    check({tag, "_swap"}, swap_sat, 0);
    check({tag, "_raw_result"}, res_raw, 0);
  endtask

  initial begin : stim
    int k;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    //          mode      A    B    sat  raw  ovf  unf  swap
    issue(EXP_MUL,  130, 125, 128, 128, 0, 0, 0);
    issue(EXP_MUL,  200, 200, 255,  17, 1, 0, 0);
    issue(EXP_MUL,  127, 127, 127, 127, 0, 0, 0);
    issue(EXP_MUL,    0,   0,   0, 129, 0, 1, 0);
    issue(EXP_DIV,   10, 200,   0, 193, 0, 1, 0);
    issue(EXP_DIV,  254, 127, 254, 254, 0, 0, 0);
    issue(EXP_DIV,  255, 127, 255, 255, 1, 0, 0);
    issue(EXP_DIFF,  20,  50,  30,  30, 0, 0, 1);
    issue(EXP_DIFF,  50,  20,  30,  30, 0, 0, 0);
    issue(EXP_DIFF,  50,  50,   0,   0, 0, 0, 0);
    issue(EXP_NORM, 100,   3,  97,  97, 0, 0, 0);
    issue(EXP_NORM,   5,   5,   0,   0, 0, 1, 0);

    // start held high through a MUL: mid-op operands must be ignored and the
    // DIFF taken only on the done cycle, three cycles after the first accept.
    @(negedge clk);
    start = 1'b1; mode = EXP_MUL; oper_a = 8'd130; oper_b = 8'd125;
    @(posedge clk); #1;
    k = cyc;
    push(k + 2, 128, 128, 0, 0, 0);
    push(k + 5, 30, 30, 0, 0, 1);
    @(negedge clk);
    mode = EXP_DIFF; oper_a = 8'd20; oper_b = 8'd50;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // clr_i in S2: no done, previous result retained.
    issue(EXP_DIFF, 50, 20, 30, 30, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; mode = EXP_DIV; oper_a = 8'd254; oper_b = 8'd127;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", busy_sat, 0);
    check("clr_result_kept", res_sat, 30);
    check("clr_raw_result_kept", res_raw, 30);
    @(negedge clk);

    // clr_i with start_i in IDLE: start dropped.
    start = 1'b1; clr = 1'b1; mode = EXP_MUL; oper_a = 8'd1; oper_b = 8'd1;
    @(posedge clk); #1;
    check("clr_start_idle_busy", busy_sat, 0);
    @(negedge clk);
    start = 1'b0; clr = 1'b0;

    // Reset in S1 after a result with flags set: everything back to 0.
    issue(EXP_MUL, 200, 200, 255, 17, 1, 0, 0);
    @(negedge clk);
    start = 1'b1; mode = EXP_DIFF; oper_a = 8'd20; oper_b = 8'd50;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero("midop_reset");
    @(negedge clk);
    start = 1'b0; rst = 1'b1;

    issue(EXP_NORM, 100, 3, 97, 97, 0, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", q_sat.size() + q_raw.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
